ram_bist_controller: RTL and testbench
======================================

# ram_bist_controller

Self-test initiator for the single-port RAM family (ram_single_port_v1..v4). On a start pulse it owns the RAM's write/read ports. It runs a four-phase write/read-compare march over every address, counts mismatches and captures the first failure. It sits between the RAM and the system control logic, driving the RAM inputs and consuming its data output.

## Interface
- ADDR_WIDTH, default 6: RAM address bits; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, default 8: RAM word width.
- READ_LATENCY, default 1: clocks from ram_read_addr to valid ram_rdata; legal range 0..3.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- seed  in  DATA_WIDTH  pattern seed; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until entry to DONE.
- done  out  1  level; high in DONE until the next accepted start.
- pass  out  1  valid while done: 1 if err_count == 0.
- err_count  out  ADDR_WIDTH+2  total mismatches; saturates at all-ones.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_phase  out  1  0 = first mismatch in R0, 1 = first mismatch in R1.
- ram_we  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.

## Operation
- States: IDLE, W0, R0, W1, R1, DONE.
- Accepted start clears err_count, fail_addr and fail_phase, latches seed, and moves to W0.
- Pattern: P(a) = zero-extend(a) ^ seed, truncated to DATA_WIDTH if ADDR_WIDTH > DATA_WIDTH.
- W0: ram_we=1, write address a = 0..2^AW-1, one per cycle, ram_wdata = P(a).
- R0: ram_we=0, issue ram_read_addr = 0..2^AW-1, one per cycle. Then drain READ_LATENCY cycles. Compare each returned word with P(a).
- W1: as W0 with ~P(a). R1: as R0, compared with ~P(a).
- Transitions: W0→R0→W1→R1→DONE, each after its last address (R phases include the drain). DONE→W0 on start.
- Compare pipeline: the expected word, the address and a valid bit travel through a READ_LATENCY-deep shift register aligned with ram_rdata. With READ_LATENCY=0 the compare is in the issue cycle.
- On each valid mismatch, err_count increments (saturating). If it was 0, capture fail_addr and fail_phase.
- Outside W phases ram_we=0. Outside R phases ram_read_addr holds 0. Unused address and data outputs are driven 0 in IDLE and DONE.
- Address counter wraps only by phase change; it never wraps within a phase.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset is asynchronous: ram_we drops immediately.
- Reset mid-operation aborts the test; pending pipeline compares are discarded. A later start runs a full test.
- start while busy is ignored. start in the same cycle as the DONE entry is ignored; it is sampled from the following cycle.
- Accepted start at edge 0: busy=1 and W0 addr 0 from edge 1.
- Total busy duration = 4·2^AW + 2·READ_LATENCY cycles. With the defaults this is 258.
- done, pass and the final err_count are all valid in the first DONE cycle.
- The final R1 compare completes before DONE and is counted.

## Test plan
- Reset: hold rst_n=0 with start=1 → all outputs 0 and ram_we=0. Release → remains IDLE until start.
- Good RAM (defaults), seed=8'h00, start at edge 0 → busy 1..258, done at 259, pass=1, err_count=0.
- RAM bit 3 stuck-at-0 at address 5, seed=8'h00 → R0 passes (8'h05), R1 fails (expected 8'hFA, got 8'hF2). Result: err_count=1, fail_addr=5, fail_phase=1, pass=0.
- RAM model flips bit 0 on every read, seed=8'hA5 → err_count=128, fail_addr=0, fail_phase=0.
- rst_n pulsed low during R0 → immediate IDLE with busy=0 and ram_we=0. start during a later busy period is ignored. Restart completes with pass=1 in 258 cycles.
- READ_LATENCY=2 with a good 2-stage RAM model → done after 260 busy cycles, pass=1.

Source files
------------

// File: rtl/ram_bist_controller.sv
// March self-test for a single-port RAM: W0/R0 with P(a)=a^seed, then W1/R1 with ~P(a).
// Latency: busy for 4*2^ADDR_WIDTH + 2*READ_LATENCY cycles after an accepted start.
// Backpressure: none; start is ignored while busy and on the cycle DONE is entered.
module ram_bist_controller #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_phase,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = ADDR_WIDTH + 2;
  localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam logic [CW-1:0] W_LAST = CW'((1 << ADDR_WIDTH) - 1);
  localparam logic [CW-1:0] R_LAST = CW'((1 << ADDR_WIDTH) - 1 + READ_LATENCY);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] W0   = 3'd1;
  localparam logic [2:0] R0   = 3'd2;
  localparam logic [2:0] W1   = 3'd3;
  localparam logic [2:0] R1   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic [PW-1:0]         addr_ext;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  in_w, in_r, issue_vld, start_ok, phase_end, mismatch;
  logic                  cmp_vld, cmp_phase;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [DATA_WIDTH-1:0] cmp_exp;

  assign addr      = cnt[ADDR_WIDTH-1:0];
  assign addr_ext  = PW'(addr);
  assign in_w      = (state == W0) || (state == W1);
  assign in_r      = (state == R0) || (state == R1);
  // cnt runs past the last address during the read drain; no new reads then
  assign issue_vld = in_r && (cnt <= W_LAST);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign phase_end = in_w ? (cnt == W_LAST) : (in_r && (cnt == R_LAST));

  always_comb begin
    exp_word = addr_ext[DATA_WIDTH-1:0] ^ seed_q;
    if ((state == W1) || (state == R1)) exp_word = ~exp_word;
  end

  assign ram_we         = in_w;
  assign ram_write_addr = in_w ? addr : '0;
  assign ram_wdata      = in_w ? exp_word : '0;
  assign ram_read_addr  = issue_vld ? addr : '0;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);
  assign pass           = done && (err_count == '0);

  // expected word, address and phase ride alongside the RAM read pipeline
  generate
    if (READ_LATENCY == 0) begin : g_nopipe
      assign cmp_vld   = issue_vld;
      assign cmp_addr  = addr;
      assign cmp_exp   = exp_word;
      assign cmp_phase = (state == R1);
    end else begin : g_pipe
      logic [READ_LATENCY-1:0] pv, pp;
      logic [ADDR_WIDTH-1:0]   pa [READ_LATENCY];
      logic [DATA_WIDTH-1:0]   pe [READ_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
          pp <= '0;
          for (int i = 0; i < READ_LATENCY; i++) begin
            pa[i] <= '0;
            pe[i] <= '0;
          end
        end else begin
          pv[0] <= issue_vld;
          pp[0] <= (state == R1);
          pa[0] <= addr;
          pe[0] <= exp_word;
          for (int i = 1; i < READ_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pp[i] <= pp[i-1];
            pa[i] <= pa[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      assign cmp_vld   = pv[READ_LATENCY-1];
      assign cmp_phase = pp[READ_LATENCY-1];
      assign cmp_addr  = pa[READ_LATENCY-1];
      assign cmp_exp   = pe[READ_LATENCY-1];
    end
  endgenerate

  assign mismatch = cmp_vld && (ram_rdata != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      seed_q     <= '0;
      err_count  <= '0;
      fail_addr  <= '0;
      fail_phase <= 1'b0;
    end else if (start_ok) begin
      state      <= W0;
      cnt        <= '0;
      seed_q     <= seed;
      err_count  <= '0;
      fail_addr  <= '0;
      fail_phase <= 1'b0;
    end else begin
      if (phase_end) begin
        cnt <= '0;
        case (state)
          W0:      state <= R0;
          R0:      state <= W1;
          W1:      state <= R1;
          R1:      state <= DONE;
          default: state <= state;
        endcase
      end else if (in_w || in_r) begin
        cnt <= cnt + 1'b1;
      end
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr  <= cmp_addr;
          fail_phase <= cmp_phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_controller.sv
// Bench for ram_bist_controller: one READ_LATENCY=1 instance with an injectable faulty RAM
// and one READ_LATENCY=2 instance with a good RAM, both checked every cycle against a timeline model.
module tb_ram_bist_controller;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] seed = 8'h00;

  logic busy0, done0, pass0, fp0, we0, busy1, done1, pass1, fp1, we1;
  logic [7:0] err0, err1, wd0, wd1, rd0, rd1, q1;
  logic [5:0] fa0, fa1, wa0, wa1, ra0, ra1;

  int tests = 0;
  int fails = 0;
  int fault_mode = 0;  // 0 good, 1 bit3 stuck-at-0 at address 5, 2 bit0 flipped on every read

  always #5 clk = ~clk;

  ram_bist_controller #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_addr(fa0), .fail_phase(fp0), .ram_we(we0),
    .ram_write_addr(wa0), .ram_read_addr(ra0), .ram_wdata(wd0), .ram_rdata(rd0));

  ram_bist_controller #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_addr(fa1), .fail_phase(fp1), .ram_we(we1),
    .ram_write_addr(wa1), .ram_read_addr(ra1), .ram_wdata(wd1), .ram_rdata(rd1));

  logic [7:0] mem0 [N];
  logic [7:0] mem1 [N];

  always @(posedge clk) begin
    if (we0) mem0[wa0] <= (fault_mode == 1 && wa0 == 6'd5) ? (wd0 & 8'hF7) : wd0;
    rd0 <= mem0[ra0] ^ ((fault_mode == 2) ? 8'h01 : 8'h00);
    if (we1) mem1[wa1] <= wd1;
    q1  <= mem1[ra1];
    rd1 <= q1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  typedef struct packed {
    logic       we;
    logic [5:0] wa;
    logic [5:0] ra;
    logic [7:0] wd;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [5:0] fa;
    logic       fp;
    logic       care_w;
    logic       care_r;
  } exp_t;

  function automatic logic [7:0] pat(input int a, input logic [7:0] sd);
    return 8'(a) ^ sd;
  endfunction

  // word the faulty RAM hands back when exp was written to address a
  function automatic logic [7:0] ram_sees(input logic [7:0] w, input int a, input int mode);
    if (mode == 1 && a == 5) return w & 8'hF7;
    if (mode == 2) return w ^ 8'h01;
    return w;
  endfunction

  // Outputs expected t cycles after the accepting edge, from the march timeline
  function automatic exp_t model(input int t, input int rl, input logic [7:0] sd,
                                 input int mode, input bit run);
    exp_t e;
    int r0s, w1s, r1s, blen, iss;
    logic [7:0] ew;
    e = '0;
    e.care_w = 1'b1;
    e.care_r = 1'b1;
    if (!run) return e;
    r0s  = N + 1;
    w1s  = 2 * N + rl + 1;
    r1s  = 3 * N + rl + 1;
    blen = 4 * N + 2 * rl;
    e.busy = (t <= blen);
    e.done = (t > blen);
    if (t >= 1 && t <= N) begin
      e.we = 1'b1; e.wa = 6'(t - 1); e.wd = pat(t - 1, sd);
    end else if (t >= w1s && t < r1s) begin
      e.we = 1'b1; e.wa = 6'(t - w1s); e.wd = ~pat(t - w1s, sd);
    end else if (e.busy) begin
      e.care_w = 1'b0;
      iss = (t >= r1s) ? t - r1s : t - r0s;
      if (iss < N) e.ra = 6'(iss);
      else e.care_r = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) begin
        ew = p ? ~pat(a, sd) : pat(a, sd);
        if ((p ? r1s : r0s) + a + rl + 1 <= t && ram_sees(ew, a, mode) != ew) begin
          if (e.err == 0) begin e.fa = 6'(a); e.fp = p[0]; end
          if (e.err != 8'hFF) e.err = e.err + 8'd1;
        end
      end
    end
    e.pass = e.done && (e.err == 0);
    return e;
  endfunction

  int mt[2] = '{0, 0};
  bit mrun[2] = '{0, 0};
  logic [7:0] msd[2];
  int mmode[2] = '{0, 0};

  task automatic check_inst(input int i, input logic we, input logic [5:0] wa,
                            input logic [5:0] ra, input logic [7:0] wd, input logic bz,
                            input logic dn, input logic ps, input logic [7:0] er,
                            input logic [5:0] fa, input logic fp);
    exp_t e;
    e = model(mt[i], i + 1, msd[i], mmode[i], mrun[i] && rst_n);
    chk($sformatf("i%0d_busy", i), bz, e.busy);
    chk($sformatf("i%0d_done", i), dn, e.done);
    chk($sformatf("i%0d_pass", i), ps, e.pass);
    chk($sformatf("i%0d_err_count", i), er, e.err);
    chk($sformatf("i%0d_fail_addr", i), fa, e.fa);
    chk($sformatf("i%0d_fail_phase", i), fp, e.fp);
    chk($sformatf("i%0d_ram_we", i), we, e.we);
    if (e.care_w) begin
      chk($sformatf("i%0d_write_addr", i), wa, e.wa);
      chk($sformatf("i%0d_wdata", i), wd, e.wd);
    end
    if (e.care_r) chk($sformatf("i%0d_read_addr", i), ra, e.ra);
  endtask

  // inputs change only at posedge+1, so at negedge they are what the next edge samples
  initial begin
    forever begin
      @(negedge clk);
      check_inst(0, we0, wa0, ra0, wd0, busy0, done0, pass0, err0, fa0, fp0);
      check_inst(1, we1, wa1, ra1, wd1, busy1, done1, pass1, err1, fa1, fp1);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) mrun[i] = 1'b0;
        else if (start && (!mrun[i] || mt[i] > 4 * N + 2 * (i + 1))) begin
          mrun[i] = 1'b1; mt[i] = 1; msd[i] = seed; mmode[i] = (i == 0) ? fault_mode : 0;
        end else if (mrun[i]) mt[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_test(input logic [7:0] s, input int mode, input bit lit, input int e_err,
                          input int e_fa, input int e_fp, input int e_pass);
    fault_mode = mode;
    seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 258; t++) begin
      start = (t > 2 && t < 250 && $urandom_range(0, 15) == 0);
      tick();
    end
    start = 1'b1;  // lands on the DONE-entry edge of the latency-1 instance
    chk("busy_last_cycle", busy0, 1);
    chk("done_before_end", done0, 0);
    tick();
    start = 1'b0;
    chk("done_first_cycle", done0, 1);
    chk("busy_after_end", busy0, 0);
    if (lit) begin
      chk("final_err_count", err0, e_err);
      chk("final_fail_addr", fa0, e_fa);
      chk("final_fail_phase", fp0, e_fp);
      chk("final_pass", pass0, e_pass);
    end
    tick();
    chk("done_held", done0, 1);
    chk("rl2_busy_last", busy1, 1);
    tick();
    chk("rl2_done", done1, 1);
    chk("rl2_pass", pass1, 1);
    tick();
    tick();
  endtask

  task automatic abort_test(input int at, input logic exp_we);
    fault_mode = 0;
    seed = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < at; t++) tick();
    chk("we_before_abort", we0, exp_we);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_we", we0, 0);
    chk("abort_rl2_busy", busy1, 0);
    chk("abort_rl2_we", we1, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    start = 1'b1;
    seed = 8'($urandom);
    repeat (3) tick();
    chk("reset_busy", busy0, 0);
    chk("reset_we", we0, 0);
    chk("reset_done", done0, 0);
    chk("reset_err", err0, 0);
    chk("reset_pass", pass0, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) tick();
    chk("idle_busy", busy0, 0);
    chk("idle_done", done0, 0);

    run_test(8'h00, 0, 1'b1, 0, 0, 0, 1);
    run_test(8'h00, 1, 1'b1, 1, 5, 1, 0);
    run_test(8'hA5, 2, 1'b1, 128, 0, 0, 0);
    abort_test(100, 1'b0);
    abort_test(150, 1'b1);
    run_test(8'h3C, 0, 1'b1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) run_test(8'($urandom), int'($urandom_range(0, 2)), 1'b0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL timeout: actual=running required=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
